// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle shared by the fetch path, the load/store path
// and the unified memory port of mem_port_arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;

  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_wmask;
  logic [DW-1:0]   d_rdata;
  logic            d_ready;

  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_wmask;
  logic [DW-1:0]   mem_rdata;
  logic            mem_ack;

  logic err;
  logic busy;

  modport master (
    input  if_req,
    input  if_addr,
    output if_rdata,
    output if_ready,
    input  d_req,
    input  d_we,
    input  d_addr,
    input  d_wdata,
    input  d_wmask,
    output d_rdata,
    output d_ready,
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    output mem_wmask,
    input  mem_rdata,
    input  mem_ack,
    output err,
    output busy
  );

  modport slave (
    output if_req,
    output if_addr,
    input  if_rdata,
    input  if_ready,
    output d_req,
    output d_we,
    output d_addr,
    output d_wdata,
    output d_wmask,
    input  d_rdata,
    input  d_ready,
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wmask,
    output mem_rdata,
    output mem_ack,
    input  err,
    input  busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter for a single-port variable-latency memory,
// with bus timeout and a fetch-starvation guard.
module mem_port_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int MAX_D_STREAK   = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.master bus
);

  localparam int WCW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int SW =
    (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  typedef struct packed {
    logic            we;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wmask;
  } mem_cmd_t;

  state_t   state_q;
  state_t   state_d;
  mem_cmd_t cmd_q;
  mem_cmd_t cmd_d;
  logic [WCW-1:0] wait_cnt;
  logic [SW-1:0]  d_streak;

  logic in_busy;
  logic streak_full;
  logic grant_d;
  logic grant_if;
  logic at_limit;
  logic tmo;
  logic done;

  logic          if_ready;
  logic          d_ready;
  logic [DW-1:0] if_rdata;
  logic [DW-1:0] d_rdata;

  assign in_busy     = (state_q != IDLE);
  assign streak_full = (d_streak == SW'(MAX_D_STREAK));
  assign grant_d     = bus.d_req &&
                       !(streak_full && bus.if_req);
  assign grant_if    = bus.if_req && !grant_d;

  // The final allowed cycle aborts unless the ack lands in it.
  assign at_limit = (TIMEOUT_CYCLES != 0) &&
                    (wait_cnt == WCW'(TIMEOUT_CYCLES - 1));
  assign tmo      = in_busy && at_limit && !bus.mem_ack;
  assign done     = in_busy && (bus.mem_ack || tmo);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      wait_cnt <= '0;
      d_streak <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      if (!in_busy) begin
        wait_cnt <= '0;
      end else if (!bus.mem_ack) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (!in_busy) begin
        if (grant_if) begin
          d_streak <= '0;
        end else if (grant_d) begin
          if (!bus.if_req) begin
            d_streak <= '0;
          end else if (!streak_full) begin
            d_streak <= d_streak + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = BUSY_D;
        end else if (grant_if) begin
          state_d = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_D: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Command is captured only at grant, so mem_* holds while busy.
  always_comb begin
    cmd_d = cmd_q;
    if (!in_busy) begin
      unique case (1'b1)
        grant_d: begin
          cmd_d.we    = bus.d_we;
          cmd_d.addr  = bus.d_addr;
          cmd_d.wdata = bus.d_wdata;
          cmd_d.wmask = bus.d_wmask;
        end
        grant_if: begin
          cmd_d.we    = 1'b0;
          cmd_d.addr  = bus.if_addr;
          cmd_d.wdata = '0;
          cmd_d.wmask = '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if_ready = (state_q == BUSY_IF) && done;
    d_ready  = (state_q == BUSY_D) && done;
    if_rdata = '0;
    d_rdata  = '0;
    if (if_ready && bus.mem_ack) begin
      if_rdata = bus.mem_rdata;
    end
    if (d_ready && bus.mem_ack) begin
      d_rdata = bus.mem_rdata;
    end
  end

  assign bus.if_ready  = if_ready;
  assign bus.d_ready   = d_ready;
  assign bus.if_rdata  = if_rdata;
  assign bus.d_rdata   = d_rdata;
  assign bus.err       = tmo;
  assign bus.busy      = in_busy;
  assign bus.mem_req   = in_busy;
  assign bus.mem_we    = cmd_q.we;
  assign bus.mem_addr  = cmd_q.addr;
  assign bus.mem_wdata = cmd_q.wdata;
  assign bus.mem_wmask = cmd_q.wmask;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table plus
// hand-written arbitration, timeout and reset sequences.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(
    .AW(32),
    .DW(32),
    .TIMEOUT_CYCLES(64),
    .MAX_D_STREAK(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          ack_at;
    logic [31:0] rdata;
    int          exp_lat;
    logic        exp_we;
    logic [3:0]  exp_mask;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_wmask   = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    bit done;
    logic rdy;
    logic other;
    logic [31:0] rd;
    @(negedge clk);
    if (v.is_d) begin
      bus.d_req   = 1'b1;
      bus.d_we    = v.we;
      bus.d_addr  = v.addr;
      bus.d_wdata = v.wdata;
      bus.d_wmask = v.wmask;
      bus.if_req  = 1'b0;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
      bus.d_req   = 1'b0;
      bus.d_we    = 1'b1;
      bus.d_wdata = 32'h5A5A_5A5A;
      bus.d_wmask = 4'hF;
    end
    @(negedge clk);
    chk({nm, ".mem_req"}, 64'(bus.mem_req), 64'd1);
    chk({nm, ".mem_addr"}, 64'(bus.mem_addr), 64'(v.addr));
    chk({nm, ".mem_we"}, 64'(bus.mem_we), 64'(v.exp_we));
    chk({nm, ".mem_wmask"}, 64'(bus.mem_wmask),
        64'(v.exp_mask));
    if (v.is_d && v.we) begin
      chk({nm, ".mem_wdata"}, 64'(bus.mem_wdata),
          64'(v.wdata));
    end
    done = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      if (c > 0) @(negedge clk);
      bus.mem_ack   = (c == v.ack_at);
      bus.mem_rdata = v.rdata;
      #1;
      rdy   = v.is_d ? bus.d_ready : bus.if_ready;
      other = v.is_d ? bus.if_ready : bus.d_ready;
      rd    = v.is_d ? bus.d_rdata : bus.if_rdata;
      if (rdy || other) begin
        done = 1'b1;
        chk({nm, ".ready"}, 64'(rdy), 64'd1);
        chk({nm, ".lat"}, 64'(c), 64'(v.exp_lat));
        chk({nm, ".other"}, 64'(other), 64'd0);
        chk({nm, ".rdata"}, 64'(rd), 64'(v.exp_rdata));
        chk({nm, ".err"}, 64'(bus.err), 64'(v.exp_err));
        chk({nm, ".addr_hold"}, 64'(bus.mem_addr),
            64'(v.addr));
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
      end
    end
    if (!done) begin
      chk({nm, ".ready_seen"}, 64'd0, 64'd1);
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk({nm, ".req_drop"}, 64'(bus.mem_req), 64'd0);
    chk({nm, ".busy_drop"}, 64'(bus.busy), 64'd0);
  endtask

  int exp_kind[6];
  int kind;
  bit seen;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    idle_inputs();

    // is_d we addr wdata mask ack_at rdata lat we mask rdata err
    tbl[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 0,
               32'h0050_0093, 0, 1'b0, 4'h0,
               32'h0050_0093, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'h0, 2,
               32'hCAFE_F00D, 2, 1'b0, 4'h0,
               32'hCAFE_F00D, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'h3,
               1, 32'hFFFF_FFFF, 1, 1'b1, 4'h3,
               32'hFFFF_FFFF, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 5,
               32'h0000_0013, 5, 1'b0, 4'h0,
               32'h0000_0013, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 255,
               32'hAAAA_5555, 63, 1'b0, 4'h0,
               32'h0000_0000, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 32'h0000_0048, 32'h0, 4'h0, 63,
               32'h1234_ABCD, 63, 1'b0, 4'h0,
               32'h1234_ABCD, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 32'h0000_004C, 32'h0, 4'h0, 255,
               32'h7777_7777, 63, 1'b0, 4'h0,
               32'h0000_0000, 1'b1};
    exp_kind = '{1, 1, 1, 1, 0, 1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.mem_req", 64'(bus.mem_req), 64'd0);
    chk("rst.busy", 64'(bus.busy), 64'd0);
    chk("rst.mem_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst.mem_we", 64'(bus.mem_we), 64'd0);
    chk("rst.mem_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("rst.mem_wmask", 64'(bus.mem_wmask), 64'd0);
    chk("rst.readies",
        64'({bus.if_ready, bus.d_ready, bus.err}), 64'd0);
    reset = 1'b0;

    // Stray ack while idle.
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hFFFF_0000;
    #1;
    chk("idle_ack.readies",
        64'({bus.if_ready, bus.d_ready, bus.err}), 64'd0);
    chk("idle_ack.if_rdata", 64'(bus.if_rdata), 64'd0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("idle_ack.mem_req", 64'(bus.mem_req), 64'd0);

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i], $sformatf("vec%0d", i));
    end

    // Simultaneous store and fetch: store first, then gap, then fetch.
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0050;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h0000_0100;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_wmask = 4'hF;
    @(negedge clk);
    chk("sim.d_we", 64'(bus.mem_we), 64'd1);
    chk("sim.d_addr", 64'(bus.mem_addr), 64'h100);
    chk("sim.d_wdata", 64'(bus.mem_wdata), 64'hDEAD_BEEF);
    chk("sim.d_wmask", 64'(bus.mem_wmask), 64'hF);
    bus.mem_ack = 1'b1;
    #1;
    chk("sim.d_ready", 64'({bus.d_ready, bus.if_ready}),
        64'b10);
    bus.d_req = 1'b0;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    chk("sim.gap", 64'(bus.mem_req), 64'd0);
    @(negedge clk);
    chk("sim.if_req", 64'(bus.mem_req), 64'd1);
    chk("sim.if_addr", 64'(bus.mem_addr), 64'h50);
    chk("sim.if_we", 64'({bus.mem_we, bus.mem_wmask}), 64'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_006F;
    #1;
    chk("sim.if_ready", 64'({bus.d_ready, bus.if_ready}),
        64'b01);
    chk("sim.if_rdata", 64'(bus.if_rdata), 64'h6F);
    bus.if_req = 1'b0;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;

    // Data streak with fetch held: D,D,D,D,IF,D.
    @(negedge clk);
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0000_0200;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h0000_0300;
    bus.d_wmask = 4'h0;
    for (int g = 0; g < 6; g++) begin
      seen = 1'b0;
      for (int w = 0; w < 10 && !seen; w++) begin
        @(negedge clk);
        seen = bus.mem_req;
      end
      if (!seen) begin
        chk($sformatf("streak%0d.grant", g), 64'd0, 64'd1);
      end
      kind = (bus.mem_addr == 32'h300) ? 1 : 0;
      chk($sformatf("streak%0d.kind", g), 64'(kind),
          64'(exp_kind[g]));
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h100 + 32'(g);
      #1;
      if (kind == 1) begin
        chk($sformatf("streak%0d.rdy", g),
            64'({bus.d_ready, bus.if_ready}), 64'b10);
      end else begin
        chk($sformatf("streak%0d.rdy", g),
            64'({bus.d_ready, bus.if_ready}), 64'b01);
        bus.if_req = 1'b0;
      end
      if (g == 5) bus.d_req = 1'b0;
      @(posedge clk);
      #1;
      bus.mem_ack = 1'b0;
    end
    bus.if_req = 1'b0;

    // Reset in the third BUSY_D cycle, then a late ack.
    @(negedge clk);
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b1;
    bus.d_addr = 32'h0000_0080;
    bus.d_wdata = 32'h0BAD_CAFE;
    bus.d_wmask = 4'hC;
    @(negedge clk);
    chk("rmid.busy0", 64'(bus.mem_req), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    bus.d_req = 1'b0;
    chk("rmid.mem_req", 64'(bus.mem_req), 64'd0);
    chk("rmid.busy", 64'(bus.busy), 64'd0);
    chk("rmid.mem_bus",
        64'(bus.mem_addr | bus.mem_wdata), 64'd0);
    chk("rmid.mem_we_mask",
        64'({bus.mem_we, bus.mem_wmask}), 64'd0);
    chk("rmid.readies",
        64'({bus.if_ready, bus.d_ready, bus.err}), 64'd0);
    @(negedge clk);
    reset         = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0005;
    #1;
    chk("rmid.late_ack",
        64'({bus.if_ready, bus.d_ready, bus.err}), 64'd0);
    chk("rmid.late_rdata", 64'(bus.d_rdata), 64'd0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    run_txn(tbl[0], "rmid.fetch");

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
